// File: rtl/exec_ctrl.sv
// exec_ctrl -- run/step/halt sequencer for the single-cycle MIPS core.
//
// Decides on which cycles the core executes (PC and register-file write
// enable) and on which cycles each statistics counter increments, and issues
// a one-cycle counter clear when a program is started from IDLE.
//
// Optional feature macro: EXEC_WATCHDOG_EN
//   defined   -> 32-bit enabled-cycle watchdog forces HALT after WDOG_LIMIT
//                enabled cycles and sets the sticky wdog_trip flag.
//   undefined -> no watchdog hardware, wdog_trip tied low.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   go, step         one-cycle start/resume and single-step commands
//   halt_req         syscall-exit decode   (only meaningful while cpu_en)
//   pause_req        syscall-pause decode  (only meaningful while cpu_en)
//   is_branch        current instruction is a conditional branch
//   branch_taken     that branch's condition is true
//   is_jump          current instruction is j / jal / jr
//   cpu_en           PC and register-file write enable
//   cycle_en         cycle counter enable
//   cbr_en           taken-conditional-branch counter enable
//   jmp_en           unconditional-jump counter enable
//   cnt_clr          synchronous clear to all statistics counters
//   state[2:0]       current state code for the LED display
//   halted           high in HALT
//   wdog_trip        watchdog fired, sticky until reset

module exec_ctrl #(
    parameter int unsigned STEP_CYCLES = 1,
    parameter logic [31:0] WDOG_LIMIT  = 32'd100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       step,
    input  logic       halt_req,
    input  logic       pause_req,
    input  logic       is_branch,
    input  logic       branch_taken,
    input  logic       is_jump,
    output logic       cpu_en,
    output logic       cycle_en,
    output logic       cbr_en,
    output logic       jmp_en,
    output logic       cnt_clr,
    output logic [2:0] state,
    output logic       halted,
    output logic       wdog_trip
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_PAUSE = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] step_left_q, step_left_d;
    // 0: CLEAR exits to RUN, 1: CLEAR exits to STEP
    logic       after_clr_q, after_clr_d;
    logic       wdog_hit;

    // ------------------------------------------------------------------
    // Output decode (registered state only, plus the qualified
    // instruction-class inputs for the counter enables)
    // ------------------------------------------------------------------
    assign cpu_en   = (state_q == S_RUN) || (state_q == S_STEP);
    assign cycle_en = cpu_en;
    assign cbr_en   = cpu_en & is_branch & branch_taken;
    assign jmp_en   = cpu_en & is_jump;
    assign cnt_clr  = (state_q == S_CLEAR);
    assign halted   = (state_q == S_HALT);
    assign state    = state_q;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef EXEC_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        wdog_trip_q, wdog_trip_d;

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == S_CLEAR) begin
            wdog_d = 32'd0;
        end else if (cpu_en) begin
            wdog_d = wdog_q + 32'd1;
        end
    end

    // The comparison is against LIMIT-1 so that the cycle hitting it is
    // the LIMIT-th enabled cycle and still executes.
    assign wdog_hit    = cpu_en && (wdog_q == (WDOG_LIMIT - 32'd1));
    assign wdog_trip_d = wdog_trip_q | wdog_hit;
    assign wdog_trip   = wdog_trip_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q      <= 32'd0;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_q      <= wdog_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_hit          = 1'b0;
    assign wdog_trip         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        step_left_d = step_left_q;
        after_clr_d = after_clr_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d     = S_CLEAR;
                    after_clr_d = 1'b0;
                end else if (step) begin
                    state_d     = S_CLEAR;
                    after_clr_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (after_clr_q) begin
                    state_d     = S_STEP;
                    step_left_d = STEP_LOAD;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req || wdog_hit) begin
                    state_d = S_HALT;
                end else if (pause_req) begin
                    state_d = S_PAUSE;
                end
            end
            S_STEP: begin
                if (halt_req || wdog_hit) begin
                    state_d = S_HALT;
                end else if (pause_req) begin
                    state_d = S_PAUSE;
                end else if (step_left_q == 8'd1) begin
                    state_d = S_PAUSE;
                end else begin
                    step_left_d = step_left_q - 8'd1;
                end
            end
            S_PAUSE: begin
                if (go) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d     = S_STEP;
                    step_left_d = STEP_LOAD;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // codes 6/7 recover to IDLE
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            step_left_q <= 8'd0;
            after_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_left_q <= step_left_d;
            after_clr_q <= after_clr_d;
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

    localparam int unsigned STEP_N = 3;
    localparam int unsigned WLIM   = 20;
`ifdef EXEC_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       go, step, halt_req, pause_req, is_branch, branch_taken, is_jump;
    logic       cpu_en, cycle_en, cbr_en, jmp_en, cnt_clr, halted, wdog_trip;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    exec_ctrl #(
        .STEP_CYCLES(STEP_N),
        .WDOG_LIMIT (32'(WLIM))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .step        (step),
        .halt_req    (halt_req),
        .pause_req   (pause_req),
        .is_branch   (is_branch),
        .branch_taken(branch_taken),
        .is_jump     (is_jump),
        .cpu_en      (cpu_en),
        .cycle_en    (cycle_en),
        .cbr_en      (cbr_en),
        .jmp_en      (jmp_en),
        .cnt_clr     (cnt_clr),
        .state       (state),
        .halted      (halted),
        .wdog_trip   (wdog_trip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Behavioural reference: mode code, remaining step budget, where the
    // clear phase leads, enabled-cycle total since the last clear.
    // ------------------------------------------------------------------
    int m_st;
    int m_budget;
    bit m_to_step;
    int m_wd;
    bit m_trip;

    task automatic model_reset();
        m_st = 0; m_budget = 0; m_to_step = 0; m_wd = 0; m_trip = 0;
    endtask

    task automatic model_edge();
        bit en, hit;
        en  = (m_st == 2) || (m_st == 3);
        hit = WD_ON && en && (m_wd == int'(WLIM) - 1);
        if (hit) m_trip = 1;
        if (m_st == 1) m_wd = 0;
        else if (en) m_wd = m_wd + 1;
        case (m_st)
            0: if (go) begin m_st = 1; m_to_step = 0; end
               else if (step) begin m_st = 1; m_to_step = 1; end
            1: if (m_to_step) begin m_st = 3; m_budget = STEP_N; end
               else m_st = 2;
            2: if (halt_req || hit) m_st = 5;
               else if (pause_req) m_st = 4;
            3: begin
                m_budget = m_budget - 1;
                if (halt_req || hit) m_st = 5;
                else if (pause_req) m_st = 4;
                else if (m_budget == 0) m_st = 4;
            end
            4: if (go) m_st = 2;
               else if (step) begin m_st = 3; m_budget = STEP_N; end
            default: ;
        endcase
    endtask

    function automatic logic [9:0] model_out();
        bit en;
        en = (m_st == 2) || (m_st == 3);
        return {en, en, en && is_branch && branch_taken, en && is_jump,
                m_st == 1, 3'(m_st), m_st == 5, m_trip};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (all leave time at posedge + 1)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        go = 0; step = 0; halt_req = 0; pause_req = 0;
        is_branch = 0; branch_taken = 0; is_jump = 0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic start_run();
        go = 1; tick(); go = 0;   // CLEAR
        tick();                   // RUN
    endtask

    task automatic to_pause();
        start_run();
        pause_req = 1; tick(); pause_req = 0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [9:0] got;
        clr_inputs();
        rst = 0;
        #3;
        got = {cpu_en, cycle_en, cbr_en, jmp_en, cnt_clr, state, halted, wdog_trip};
        n_tests++;
        if (got !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", got, 10'd0);
        end
        tick();
        tick();
        rst = 1;
        #1;
        got = {cpu_en, cycle_en, cbr_en, jmp_en, cnt_clr, state, halted, wdog_trip};
        n_tests++;
        if (got !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", got, 10'd0);
        end
        tick();
    endtask

    task automatic test_go_latency();
        do_reset();
        repeat (4) tick();
        n_tests++;
        if (state !== 3'd0 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d cpu_en=%b expected 0/0", state, cpu_en);
        end
        go = 1;
        tick();
        go = 0;
        n_tests++;
        if (cnt_clr !== 1'b1 || state !== 3'd1 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL go_clear_cycle: cnt_clr=%b state=%0d cpu_en=%b expected 1/1/0",
                     cnt_clr, state, cpu_en);
        end
        tick();
        n_tests++;
        if (cnt_clr !== 1'b0 || cpu_en !== 1'b1 || state !== 3'd2) begin
            n_fail++;
            $display("FAIL go_run_cycle: cnt_clr=%b cpu_en=%b state=%0d expected 0/1/2",
                     cnt_clr, cpu_en, state);
        end
    endtask

    task automatic test_run_halt();
        int n;
        do_reset();
        start_run();
        n = 0;
        repeat (10) begin
            if (cycle_en) n++;
            tick();
        end
        halt_req = 1;
        #1;
        if (cycle_en) n++;
        tick();
        halt_req = 0;
        n_tests++;
        if (n !== 11) begin
            n_fail++;
            $display("FAIL run_halt_cycles: counted %0d cycle_en expected 11", n);
        end
        n_tests++;
        if (halted !== 1'b1 || state !== 3'd5 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL run_halt_state: halted=%b state=%0d cpu_en=%b expected 1/5/0",
                     halted, state, cpu_en);
        end
        go = 1; tick(); go = 0;
        step = 1; tick(); step = 0;
        tick();
        n_tests++;
        if (state !== 3'd5) begin
            n_fail++;
            $display("FAIL halt_terminal: state=%0d expected 5", state);
        end
    endtask

    task automatic test_step();
        int n;
        do_reset();
        to_pause();
        n_tests++;
        if (state !== 3'd4) begin
            n_fail++;
            $display("FAIL pause_entry: state=%0d expected 4", state);
        end
        step = 1; tick(); step = 0;
        n = 0;
        for (int i = 0; i < 20 && state == 3'd3; i++) begin
            if (cpu_en) n++;
            tick();
        end
        n_tests++;
        if (n !== int'(STEP_N) || state !== 3'd4) begin
            n_fail++;
            $display("FAIL step_count: enabled=%0d state=%0d expected %0d/4", n, state, STEP_N);
        end
        go = 1; step = 1; tick(); go = 0; step = 0;
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL go_wins_over_step: state=%0d expected 2", state);
        end
    endtask

    task automatic test_counters();
        int nb, nj;
        logic [2:0] bt_seq;
        bt_seq = 3'b110;   // cycle0=0, cycle1=1, cycle2=1
        do_reset();
        start_run();
        nb = 0; nj = 0;
        for (int i = 0; i < 3; i++) begin
            is_branch = 1; branch_taken = bt_seq[i]; is_jump = (i == 1);
            #1;
            if (cbr_en) nb++;
            if (jmp_en) nj++;
            tick();
        end
        clr_inputs();
        n_tests++;
        if (nb !== 2 || nj !== 1) begin
            n_fail++;
            $display("FAIL run_counter_enables: cbr=%0d jmp=%0d expected 2/1", nb, nj);
        end
        pause_req = 1; tick(); pause_req = 0;
        nb = 0; nj = 0;
        for (int i = 0; i < 3; i++) begin
            is_branch = 1; branch_taken = bt_seq[i]; is_jump = (i == 1);
            halt_req = 1;
            #1;
            if (cbr_en) nb++;
            if (jmp_en) nj++;
            tick();
        end
        clr_inputs();
        n_tests++;
        if (nb !== 0 || nj !== 0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL pause_no_enables: cbr=%0d jmp=%0d state=%0d expected 0/0/4",
                     nb, nj, state);
        end
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        start_run();
        n = 0;
        for (int i = 0; i < 60 && !halted; i++) begin
            if (cpu_en) n++;
            tick();
        end
        n_tests++;
        if (WD_ON) begin
            if (n !== int'(WLIM) || halted !== 1'b1 || wdog_trip !== 1'b1) begin
                n_fail++;
                $display("FAIL watchdog_trip: enabled=%0d halted=%b trip=%b expected %0d/1/1",
                         n, halted, wdog_trip, WLIM);
            end
        end else begin
            if (n !== 60 || halted !== 1'b0 || wdog_trip !== 1'b0) begin
                n_fail++;
                $display("FAIL no_watchdog: enabled=%0d halted=%b trip=%b expected 60/0/0",
                         n, halted, wdog_trip);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        to_pause();
        step = 1; tick(); step = 0;
        n_tests++;
        if (state !== 3'd3 || cpu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL step_entry: state=%0d cpu_en=%b expected 3/1", state, cpu_en);
        end
        #2;
        rst = 0;
        #1;
        n_tests++;
        if (cpu_en !== 1'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: cpu_en=%b state=%0d expected 0/0", cpu_en, state);
        end
        tick();
        rst = 1;
        tick();
        step = 1; tick(); step = 0;
        n_tests++;
        if (state !== 3'd1 || cnt_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL step_from_idle_clear: state=%0d cnt_clr=%b expected 1/1", state, cnt_clr);
        end
        tick();
        n_tests++;
        if (state !== 3'd3 || cpu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL step_from_idle_step: state=%0d cpu_en=%b expected 3/1", state, cpu_en);
        end
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            model_reset();
            for (int c = 0; c < 150; c++) begin
                go           = ($urandom_range(0, 9) == 0);
                step         = ($urandom_range(0, 9) == 0);
                halt_req     = ($urandom_range(0, 39) == 0);
                pause_req    = ($urandom_range(0, 7) == 0);
                is_branch    = 1'($urandom_range(0, 1));
                branch_taken = 1'($urandom_range(0, 1));
                is_jump      = 1'($urandom_range(0, 1));
                #1;
                got = {cpu_en, cycle_en, cbr_en, jmp_en, cnt_clr, state, halted, wdog_trip};
                exp = model_out();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random ep%0d cyc%0d: got %b expected %b", ep, c, got, exp);
                end
                model_edge();
                tick();
            end
        end
        clr_inputs();
    endtask

    initial begin
        clr_inputs();
        rst = 0;
        test_reset();
        test_go_latency();
        test_run_halt();
        test_step();
        test_counters();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Run/step/halt sequencer for the single-cycle MIPS core and its statistics counters. It decides on which cycles the core executes, using a PC and register-write enable, and on which cycles each `Counter` instance increments. It also issues the one-cycle counter clear at program start. It sits between the debounced board buttons and syscall decode on one side, and the PC, register file and statistics counters on the other.

## Interface
Parameters:
- `STEP_CYCLES`, default 1: enabled cycles executed per step command, range 1..255.
- `WDOG_LIMIT`, default 32'd100_000_000: enabled-cycle budget before a forced halt. Used only with `EXEC_WATCHDOG_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `go`  in  1  start/resume pulse, one cycle wide.
- `step`  in  1  single-step pulse, one cycle wide.
- `halt_req`  in  1  syscall-exit decode. Valid only on cycles where `cpu_en` is high.
- `pause_req`  in  1  syscall-pause decode. Valid only on cycles where `cpu_en` is high.
- `is_branch`  in  1  current instruction is a conditional branch.
- `branch_taken`  in  1  condition of the conditional branch is true.
- `is_jump`  in  1  current instruction is j, jal or jr.
- `cpu_en`  out  1  PC and register-file write enable.
- `cycle_en`  out  1  cycle counter enable.
- `cbr_en`  out  1  taken-conditional-branch counter enable.
- `jmp_en`  out  1  unconditional-jump counter enable.
- `cnt_clr`  out  1  synchronous clear to all statistics counters.
- `state`  out  3  current state encoding, for the LED display.
- `halted`  out  1  high in HALT.
- `wdog_trip`  out  1  watchdog fired. Sticky until reset.

## Operation
State encodings:
- IDLE = 0, CLEAR = 1, RUN = 2, STEP = 3, PAUSE = 4, HALT = 5.
- Codes 6 and 7 are illegal and go to IDLE on the next edge.

Internal registers:
- `step_left`: 8 bits.
- `after_clr`: 1 bit. Records whether CLEAR exits to RUN or STEP.
- Watchdog counter: 32 bits, present only with `EXEC_WATCHDOG_EN`.

Transitions, in priority order within each state:
- IDLE:
  - `go` → CLEAR, with `after_clr` = RUN.
  - else `step` → CLEAR, with `after_clr` = STEP.
- CLEAR: → `after_clr` target. When the target is STEP, load `step_left` = `STEP_CYCLES`.
- RUN:
  - `halt_req` → HALT.
  - else `pause_req` → PAUSE.
  - `go` and `step` are ignored.
- STEP:
  - `halt_req` → HALT.
  - else `pause_req` → PAUSE.
  - else `step_left` == 1 → PAUSE.
  - else stay in STEP and decrement `step_left`.
- PAUSE:
  - `go` → RUN.
  - else `step` → STEP, loading `step_left` = `STEP_CYCLES`.
  - `go` wins when both are high.
- HALT: terminal. `go` and `step` are ignored; only reset leaves HALT.

Outputs, all decoded combinationally from the registered state:
- `cpu_en` = (state == RUN) or (state == STEP).
- `cycle_en` = `cpu_en`.
- `cbr_en` = `cpu_en` & `is_branch` & `branch_taken`.
- `jmp_en` = `cpu_en` & `is_jump`.
- `cnt_clr` = (state == CLEAR).
- `halted` = (state == HALT).

Further rules:
- The cycle on which `halt_req` or `pause_req` is sampled is itself enabled. The syscall instruction retires and is counted.
- `halt_req`, `pause_req`, `is_branch`, `branch_taken` and `is_jump` have no effect while `cpu_en` is low.

## Timing
- Reset values:
  - state = IDLE, `step_left` = 0, `after_clr` = 0, watchdog = 0.
  - All outputs are 0, `state` = 3'd0.
- Reset is asynchronous. Asserting it mid-RUN drops `cpu_en` without waiting for a clock edge.
- Latency from `go` in IDLE:
  - sampled at edge N;
  - `cnt_clr` is high for cycle N+1;
  - `cpu_en` first goes high in cycle N+2.
- `go` in PAUSE: `cpu_en` goes high the cycle after sampling.
- Step command: exactly `STEP_CYCLES` enabled cycles, then PAUSE, unless cut short by `halt_req` or `pause_req`.
- `step` held high is sampled again each time PAUSE is entered. Upstream must supply single-cycle pulses.

## Configuration
- `EXEC_WATCHDOG_EN` defined:
  - A 32-bit counter increments on every `cpu_en` cycle and is cleared in CLEAR.
  - When it equals `WDOG_LIMIT - 1` on an enabled cycle, the next state is HALT and `wdog_trip` is set.
  - A `halt_req` on the same cycle also gives HALT; `wdog_trip` is still set.
- `EXEC_WATCHDOG_EN` undefined:
  - No watchdog counter is built.
  - `wdog_trip` is tied to 0.
  - The program can run indefinitely.

## Test plan
- Reset, then `go` pulse at cycle 5: `cnt_clr` high in cycle 6 only, `cpu_en` high from cycle 7, `state` = 2.
- RUN for 10 enabled cycles, then `halt_req` for one cycle: 11 `cycle_en` cycles total, then `halted` = 1. A later `go` leaves `state` = 5.
- Set `STEP_CYCLES` = 3 and give a `step` pulse from PAUSE: exactly 3 `cpu_en` cycles, then `state` = 4. `go` and `step` in the same cycle in PAUSE → RUN.
- In RUN, drive `is_branch` = 1, `branch_taken` = 0/1/1 and `is_jump` = 1 on one cycle: `cbr_en` pulses twice, `jmp_en` once. The same inputs in PAUSE give no pulses.
- With `EXEC_WATCHDOG_EN` and `WDOG_LIMIT` = 20, after `go`: exactly 20 enabled cycles, then HALT with `wdog_trip` = 1.
- Assert `rst` low mid-STEP, between clock edges: `cpu_en` drops immediately, `state` = 0. After release, a `step` pulse goes through CLEAR before STEP.
